// File: rtl/user_io_spi_host.sv
// user_io_spi_host: mode-0 SPI host; sends cmd byte plus 0..4 payload bytes to user_io, captures MISO payload.
// Latency: ss_n falls 1 cycle after start; done pulses HALF_PERIOD*(1+2N) cycles after that (N = 8*(1+len)).
// Backpressure: none; start is taken only when idle (busy=0), otherwise dropped. Optional macro: USER_IO_SPI_HOST_RX_EN.
module user_io_spi_host #(
  parameter int HALF_PERIOD = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  cmd,
  input  logic [2:0]  len,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        spi_sck,
  output logic        spi_ss_n,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, END} state_t;

  localparam logic [7:0] HP = 8'(HALF_PERIOD);

  state_t      state;
  logic [39:0] tx;        // {cmd, wdata}, MSB goes out next
  logic [5:0]  bit_cnt;   // index of the bit currently on the wire
  logic [5:0]  last_bit;  // N-1
  logic [7:0]  div_cnt;
  logic [2:0]  len_c;

  // Payload length above 4 bytes is clamped to 4.
  assign len_c = (len > 3'd4) ? 3'd4 : len;

`ifdef USER_IO_SPI_HOST_RX_EN
  logic [31:0] rx;
  logic [5:0]  next_bit;
  logic [5:0]  rx_idx;

  // Payload bit k (k >= 8, counting from the cmd MSB) lands in rdata[39-k].
  assign next_bit = bit_cnt + 6'd1;
  assign rx_idx   = 6'd39 - next_bit;
  assign rdata    = rx;
`else
  logic unused_miso;

  assign unused_miso = spi_miso;
  assign rdata       = '0;
`endif

  // Transaction sequencer with registered SPI pins and status outputs.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= IDLE;
      spi_sck  <= 1'b0;
      spi_ss_n <= 1'b1;
      spi_mosi <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tx       <= '0;
      bit_cnt  <= '0;
      last_bit <= '0;
      div_cnt  <= '0;
`ifdef USER_IO_SPI_HOST_RX_EN
      rx       <= '0;
`endif
    end else begin
      case (state)
        // END is the done cycle; it behaves like IDLE so a start right after done is accepted.
        IDLE, END: begin
          done <= 1'b0;
          if (start) begin
            state    <= SETUP;
            tx       <= {cmd, wdata};
            last_bit <= {len_c, 3'b111};
            bit_cnt  <= '0;
            div_cnt  <= '0;
`ifdef USER_IO_SPI_HOST_RX_EN
            rx       <= '0;
`endif
          end else begin
            state <= IDLE;
          end
        end
        // The start edge itself is spent here too, so SETUP spans HALF_PERIOD+1 cycles
        // and the pins show the select phase for exactly HALF_PERIOD of them.
        SETUP: begin
          spi_ss_n <= 1'b0;
          busy     <= 1'b1;
          spi_mosi <= tx[39];
          if (div_cnt == HP) begin
            state   <= SHIFT_HI;
            spi_sck <= 1'b1;
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        SHIFT_HI: begin
          if (div_cnt == HP - 8'd1) begin
            state    <= SHIFT_LO;
            spi_sck  <= 1'b0;
            div_cnt  <= '0;
            tx       <= {tx[38:0], 1'b0};
            // After the last bit MOSI returns low for the hold phase.
            spi_mosi <= (bit_cnt == last_bit) ? 1'b0 : tx[38];
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        SHIFT_LO: begin
          if (div_cnt == HP - 8'd1) begin
            div_cnt <= '0;
            if (bit_cnt == last_bit) begin
              state    <= END;
              spi_ss_n <= 1'b1;
              busy     <= 1'b0;
              done     <= 1'b1;
              bit_cnt  <= '0;
            end else begin
              state   <= SHIFT_HI;
              spi_sck <= 1'b1;
              bit_cnt <= bit_cnt + 6'd1;
`ifdef USER_IO_SPI_HOST_RX_EN
              // MISO is sampled on the edge raising SCK; cmd-byte bits are dropped.
              if (next_bit >= 6'd8) rx[rx_idx[4:0]] <= spi_miso;
`endif
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_user_io_spi_host.sv
// Bench for user_io_spi_host: directed and random transactions against a bit-stream reference model.
// Edge k counts rising clk_sys edges after the edge that samples start; outputs are read on falling edges.
// MISO is either looped back from MOSI or random, changed only on falling edges.
module tb_user_io_spi_host;

  localparam int HP = 4;
`ifdef USER_IO_SPI_HOST_RX_EN
  localparam bit RX = 1'b1;
`else
  localparam bit RX = 1'b0;
`endif

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  cmd;
  logic [2:0]  len;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        spi_sck;
  logic        spi_ss_n;
  logic        spi_mosi;
  logic        spi_miso;
  logic        loopback;
  logic        rnd_miso;

  int tests = 0;
  int fails = 0;

  assign spi_miso = loopback ? spi_mosi : rnd_miso;

  always #5 clk_sys = ~clk_sys;

  user_io_spi_host #(.HALF_PERIOD(HP)) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .start    (start),
    .cmd      (cmd),
    .len      (len),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .rdata    (rdata),
    .spi_sck  (spi_sck),
    .spi_ss_n (spi_ss_n),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs one transaction starting at the current falling edge and returns at the falling
  // edge where done is seen (so a following call puts start on the edge after done).
  task automatic run_txn(input logic [7:0] c, input logic [2:0] l, input logic [31:0] w,
                         input logic lb, input logic ign, input string tag);
    int          n, rises, first_low, last_low, done_k, hold_bad;
    logic        prev_sck;
    logic [39:0] frame, gotm;
    logic        mb [40];
    logic [31:0] exp_rd;
    n     = 8 * (1 + ((l > 3'd4) ? 4 : int'(l)));
    frame = {c, w};
    loopback = lb; cmd = c; len = l; wdata = w; start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
    cmd = 8'($urandom); len = 3'($urandom); wdata = $urandom;
    check({tag, "_done_low_at_start"}, done, 0);
    rises = 0; first_low = -1; last_low = -1; done_k = -1; hold_bad = 0;
    gotm = '0; prev_sck = 1'b0;
    for (int i = 0; i < 40; i++) mb[i] = 1'b0;
    for (int k = 1; k < 3000 && done_k < 0; k++) begin
      @(negedge clk_sys);
      if (spi_sck && !prev_sck) begin
        if (rises < 40) mb[rises] = spi_miso;
        gotm = {gotm[38:0], spi_mosi};
        rises++;
      end
      prev_sck = spi_sck;
      if (rises == n && !spi_sck && !spi_ss_n && spi_mosi) hold_bad++;
      if (!spi_ss_n) begin
        if (first_low < 0) first_low = k;
        last_low = k;
      end
      if (done) done_k = k;
      if (ign) start = ((k + 1) == 10 || (k + 1) == 197);
      rnd_miso = 1'($urandom);
    end
    start = 1'b0;
    exp_rd = '0;
    for (int i = 8; i < n; i++) if (RX) exp_rd[39 - i] = mb[i];
    check({tag, "_sck_rises"}, rises, n);
    check({tag, "_mosi_stream"}, gotm, frame >> (40 - n));
    check({tag, "_done_edge"}, done_k, 1 + HP * (1 + 2 * n));
    check({tag, "_ss_first_low"}, first_low, 1);
    check({tag, "_ss_last_low"}, last_low, 1 + HP * (1 + 2 * n) - 1);
    check({tag, "_hold_mosi"}, hold_bad, 0);
    check({tag, "_idle_at_done"}, {busy, spi_ss_n, spi_sck}, 3'b010);
    check({tag, "_rdata"}, rdata, exp_rd);
  endtask

  initial begin
    int aborted_done, aborted_busy;
    logic [31:0] keep;
    reset = 1'b1; start = 1'b0; cmd = '0; len = '0; wdata = '0;
    loopback = 1'b0; rnd_miso = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("reset_outputs", {busy, done, spi_sck, spi_ss_n, spi_mosi}, 5'b00010);
    check("reset_rdata", rdata, 0);
    reset = 1'b0;
    @(negedge clk_sys);

    // Plain write of cmd plus two payload bytes.
    run_txn(8'h01, 3'd2, 32'hA55A0000, 1'b0, 1'b0, "write");
    @(negedge clk_sys);
    check("write_done_one_cycle", {done, busy}, 2'b00);

    // Loopback of four bytes; rdata holds until the next start.
    run_txn(8'h02, 3'd4, 32'hDEADBEEF, 1'b1, 1'b0, "loop");
    check("loop_rdata_value", rdata, RX ? 32'hDEADBEEF : 32'h0);
    keep = rdata;
    repeat (5) @(negedge clk_sys);
    check("loop_rdata_stable", rdata, keep);

    // Clamped length and minimum length.
    run_txn(8'h5C, 3'd7, 32'h12345678, 1'b1, 1'b0, "clamp");
    @(negedge clk_sys);
    run_txn(8'hC3, 3'd0, 32'hFFFFFFFF, 1'b1, 1'b0, "min");
    check("min_rdata_zero", rdata, 0);
    @(negedge clk_sys);

    // Starts at edges 10 and 197 are ignored; start on the edge after done is taken.
    run_txn(8'h01, 3'd2, 32'hA55A0000, 1'b0, 1'b1, "rules");
    run_txn(8'h81, 3'd1, 32'h3C000000, 1'b1, 1'b0, "b2b");
    repeat (3) @(negedge clk_sys);
    check("no_queued_txn", {busy, spi_ss_n}, 2'b01);

    // Reset in the middle of a transfer aborts it without done.
    loopback = 1'b1; cmd = 8'h01; len = 3'd2; wdata = 32'hFFFF0000; start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
    for (int k = 1; k <= 101; k++) begin
      @(negedge clk_sys);
      if (k == 99) reset = 1'b1;
      if (k == 100) reset = 1'b0;
    end
    check("abort_pins", {spi_ss_n, spi_sck, spi_mosi, busy, done}, 5'b10000);
    check("abort_rdata", rdata, 0);
    aborted_done = 0; aborted_busy = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk_sys);
      if (done) aborted_done++;
      if (busy) aborted_busy++;
    end
    check("abort_no_done", aborted_done, 0);
    check("abort_stays_idle", aborted_busy, 0);

    // Start together with reset is ignored.
    reset = 1'b1; start = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("start_with_reset", {busy, spi_ss_n}, 2'b01);

    // Random transactions with looped or random MISO.
    for (int t = 0; t < 8; t++) begin
      run_txn(8'($urandom), 3'($urandom), $urandom, 1'($urandom), 1'b0, $sformatf("rnd%0d", t));
      repeat ($urandom_range(1, 3)) @(negedge clk_sys);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
